// File: rtl/rv_pkg.sv
// Shared definitions for the RV memory-stage load path: access sizes,
// load FSM state encoding and the word-span rule.
package rv_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD0  = 2'b01,
        ST_RD1  = 2'b10,
        ST_OUT  = 2'b11
    } state_e;

    // Reserved size 2'b11 behaves as a word access.
    function automatic logic spans_word(input logic [1:0] size, input logic [1:0] off);
        logic span;
        case (size)
            SZ_B:    span = 1'b0;
            SZ_H:    span = (off == 2'b11);
            default: span = (off != 2'b00);
        endcase
        return span;
    endfunction

endpackage

// File: rtl/rv_load_extract.sv
// Combinational lane mux: right-aligns the addressed bytes of {hi,lo}
// and sign- or zero-extends them to 32 bits.
module rv_load_extract
    import rv_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sig_i,
    output logic [31:0] d_o
);

    logic [31:0] win_s;
    logic        fill_s;

    // Shift the byte window down, then extend according to access size.
    always_comb begin
        win_s  = 32'(data_i >> {off_i, 3'b000});
        fill_s = 1'b0;
        d_o    = win_s;
        case (size_i)
            SZ_B: begin
                fill_s = sig_i & win_s[7];
                d_o    = {{24{fill_s}}, win_s[7:0]};
            end
            SZ_H: begin
                fill_s = sig_i & win_s[15];
                d_o    = {{16{fill_s}}, win_s[15:0]};
            end
            default: begin
                fill_s = 1'b0;
                d_o    = win_s;
            end
        endcase
    end

endmodule

// File: rtl/rv_load_align.sv
// Load-data alignment unit: issues one or two word-aligned reads per load,
// merges them and presents the extended result with a one-cycle strobe.
module rv_load_align
    import rv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic        sig_i,
    output logic        busy_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_d_i,
    output logic        ce_o,
    output logic [31:0] d_o,
    output logic        split_o
);

    state_e      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sig_q, sig_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] d_q, d_d;
    logic        busy_q, busy_d;
    logic        req_q, req_d;
    logic        ce_q, ce_d;
    logic        split_q, split_d;
    logic [63:0] ext_in_s;
    logic [31:0] ext_out_s;
    logic        span_s;

    // In RD0 the incoming word is lo with hi forced to zero; in RD1 it is hi.
    always_comb begin
        span_s = spans_word(size_q, off_q);
        if (state_q == ST_RD1) begin
            ext_in_s = {mem_d_i, lo_q};
        end else begin
            ext_in_s = {32'h0000_0000, mem_d_i};
        end
    end

    rv_load_extract u_extract (
        .data_i (ext_in_s),
        .off_i  (off_q),
        .size_i (size_q),
        .sig_i  (sig_q),
        .d_o    (ext_out_s)
    );

    // Next-state logic; output registers are loaded from the next state.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        sig_d   = sig_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        d_d     = d_q;
        split_d = split_q;
        case (state_q)
            ST_IDLE: begin
                if (ce_i) begin
                    off_d   = addr_i[1:0];
                    size_d  = size_i;
                    sig_d   = sig_i;
                    addr_d  = {addr_i[31:2], 2'b00};
                    state_d = ST_RD0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD0: begin
                if (mem_ack_i) begin
                    lo_d = mem_d_i;
                    if (span_s) begin
                        addr_d  = addr_q + 32'd4;
                        state_d = ST_RD1;
                    end else begin
                        d_d     = ext_out_s;
                        split_d = 1'b0;
                        state_d = ST_OUT;
                    end
                end else begin
                    state_d = ST_RD0;
                end
            end
            ST_RD1: begin
                if (mem_ack_i) begin
                    d_d     = ext_out_s;
                    split_d = 1'b1;
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_RD1;
                end
            end
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        req_d  = (state_d == ST_RD0) || (state_d == ST_RD1);
        ce_d   = (state_d == ST_OUT);
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            sig_q   <= 1'b0;
            addr_q  <= 32'h0000_0000;
            lo_q    <= 32'h0000_0000;
            d_q     <= 32'h0000_0000;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            ce_q    <= 1'b0;
            split_q <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sig_q   <= sig_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
            ce_q    <= ce_d;
            split_q <= split_d;
        end
    end

    assign busy_o     = busy_q;
    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign ce_o       = ce_q;
    assign d_o        = d_q;
    assign split_o    = split_q;

endmodule

// File: tb/tb_rv_load_align.sv
// Scoreboard bench for rv_load_align: stimulus pushes expected results,
// a bus responder plays memory, a monitor checks every ce_o.
module tb_rv_load_align;

    logic        clk_i;
    logic        rst_ni;
    logic        ce_i;
    logic [31:0] addr_i;
    logic [1:0]  size_i;
    logic        sig_i;
    logic        busy_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_d_i;
    logic        ce_o;
    logic [31:0] d_o;
    logic        split_o;

    typedef struct {
        logic [31:0] d;
        logic        split;
        int          edge_n;
    } exp_t;

    exp_t        exp_q[$];
    int          wait_q[$];
    logic [31:0] data_q[$];
    logic [31:0] raddr_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ce_count = 0;
    bit late_ack = 1'b0;

    rv_load_align dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ce_i       (ce_i),
        .addr_i     (addr_i),
        .size_i     (size_i),
        .sig_i      (sig_i),
        .busy_o     (busy_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_d_i    (mem_d_i),
        .ce_o       (ce_o),
        .d_o        (d_o),
        .split_o    (split_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_evt(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%h required=none", name, act);
    endtask

    // Reference: pick bytes addr..addr+n-1 from the little-endian byte stream.
    function automatic logic [31:0] ref_load(input logic [31:0] lo, input logic [31:0] hi,
                                             input logic [1:0] off, input int n, input logic sg);
        logic [7:0]  b[8];
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            b[k]     = lo[8*k +: 8];
            b[k + 4] = hi[8*k +: 8];
        end
        r = 32'h0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = b[int'(off) + k];
        if (sg && n < 4 && b[int'(off) + n - 1][7])
            for (int k = n; k < 4; k++) r[8*k +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Memory responder: waits the scripted number of cycles, then acks.
    initial begin
        int cnt;
        cnt       = -1;
        mem_ack_i = 1'b0;
        mem_d_i   = 32'h0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = late_ack;
            mem_d_i   = $urandom;
            if (!rst_ni) begin
                cnt = -1;
            end else if (mem_req_o) begin
                if (cnt < 0) cnt = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                if (cnt == 0) begin
                    mem_ack_i = 1'b1;
                    mem_d_i   = (data_q.size() > 0) ? data_q.pop_front() : 32'h0;
                    if (raddr_q.size() > 0) chk("rd_addr", mem_addr_o, raddr_q.pop_front());
                    else fail_evt("rd_unexpected", mem_addr_o);
                    cnt = -1;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: every ce_o must match the oldest expectation, on time.
    initial begin
        exp_t e;
        bit   prev_ce;
        prev_ce = 1'b0;
        forever begin
            @(negedge clk_i);
            if (prev_ce && rst_ni) chk("busy_after_out", {31'b0, busy_o}, 32'd0);
            prev_ce = ce_o;
            if (ce_o) begin
                ce_count++;
                if (exp_q.size() == 0) begin
                    fail_evt("ce_unexpected", d_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("d_o", d_o, e.d);
                    chk("split_o", {31'b0, split_o}, {31'b0, e.split});
                    chk("ce_cycle", 32'(cyc), 32'(e.edge_n));
                    chk("busy_at_out", {31'b0, busy_o}, 32'd1);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic [31:0] lo, input logic [31:0] hi, input int w0, input int w1);
        int   n;
        int   guard;
        bit   sp;
        exp_t e;
        guard = 0;
        @(negedge clk_i);
        while (busy_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        if (busy_o) fail_evt("busy_timeout", a);
        n  = size_bytes(sz);
        sp = (int'(a[1:0]) + n) > 4;
        wait_q.push_back(w0);
        data_q.push_back(lo);
        raddr_q.push_back({a[31:2], 2'b00});
        if (sp) begin
            wait_q.push_back(w1);
            data_q.push_back(hi);
            raddr_q.push_back({a[31:2], 2'b00} + 32'd4);
        end
        e.d      = ref_load(lo, sp ? hi : 32'h0, a[1:0], n, sg);
        e.split  = sp;
        e.edge_n = cyc + 2 + w0 + (sp ? 1 + w1 : 0);
        exp_q.push_back(e);
        ce_i   = 1'b1;
        addr_i = a;
        size_i = sz;
        sig_i  = sg;
        @(negedge clk_i);
        ce_i   = 1'b0;
        addr_i = $urandom;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"},  {31'b0, busy_o},    32'd0);
        chk({tag, "_req"},   {31'b0, mem_req_o}, 32'd0);
        chk({tag, "_addr"},  mem_addr_o,         32'd0);
        chk({tag, "_ce"},    {31'b0, ce_o},      32'd0);
        chk({tag, "_d"},     d_o,                32'd0);
        chk({tag, "_split"}, {31'b0, split_o},   32'd0);
    endtask

    initial begin
        int guard;
        int saved_ce;
        logic [31:0] a;
        rst_ni = 1'b0;
        ce_i   = 1'b0;
        addr_i = 32'h0;
        size_i = 2'b00;
        sig_i  = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        issue(32'h0000_0100, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 0, 0);
        issue(32'h0000_0103, 2'b00, 1'b1, 32'h8011_2233, 32'h0, 0, 0);
        issue(32'h0000_0103, 2'b00, 1'b0, 32'h8011_2233, 32'h0, 0, 0);
        issue(32'h0000_0203, 2'b01, 1'b1, 32'hAA00_0000, 32'h0000_00F1, 0, 0);
        issue(32'hFFFF_FFFE, 2'b10, 1'b0, 32'h5566_1234, 32'hABCD_7788, 0, 0);

        // Wait states with ce_i pulsed while busy; the pulses must be dropped.
        issue(32'h0000_0300, 2'b10, 1'b1, 32'h1234_5678, 32'h0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            chk("req_held", {31'b0, mem_req_o}, 32'd1);
            ce_i   = (i < 2);
            addr_i = 32'h0000_0500 + 32'(i);
            @(negedge clk_i);
        end
        ce_i = 1'b0;

        // Abort a split load while waiting on its second read.
        issue(32'h0000_0403, 2'b10, 1'b1, 32'h1111_1111, 32'h2222_2222, 0, 6);
        guard = 0;
        while (!(mem_req_o && mem_addr_o == 32'h0000_0404) && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        chk("rd1_reached", mem_addr_o, 32'h0000_0404);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_q.delete();
        wait_q.delete();
        data_q.delete();
        raddr_q.delete();
        saved_ce = ce_count;
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b1;
        @(negedge clk_i);
        late_ack = 1'b1;
        @(negedge clk_i);
        late_ack = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("no_ce_after_abort", 32'(ce_count), 32'(saved_ce));
        chk("idle_after_abort", {31'b0, busy_o}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a[31:2] = 30'h3FFF_FFFF;
            issue(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        guard = 0;
        while ((exp_q.size() > 0 || busy_o) && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_load_align.md
# rv_load_align

Load-data alignment unit for the RV core's memory stage. It is the read-side counterpart of the store-side byte-lane shifting: it accepts a load request (byte address, size, signedness) and issues one or two word-aligned reads on the data bus. It merges the returned words, right-aligns and sign/zero-extends the addressed bytes, and presents a 32-bit result with a one-cycle `ce_o` strobe to writeback.

## Interface
Parameters:
- none (data/address width fixed at 32)

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `ce_i`  in  1  load request strobe; sampled only when `busy_o`=0
- `addr_i`  in  32  byte address of load
- `size_i`  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- `sig_i`  in  1  1 = sign-extend, 0 = zero-extend (ignored for word)
- `busy_o`  out  1  high whenever state ≠ IDLE
- `mem_req_o`  out  1  read request to data bus
- `mem_addr_o`  out  32  word-aligned read address (bits[1:0]=00)
- `mem_ack_i`  in  1  read data valid this cycle
- `mem_d_i`  in  32  read data, little-endian lanes
- `ce_o`  out  1  one-cycle result valid pulse
- `d_o`  out  32  aligned, extended load result
- `split_o`  out  1  registered with `ce_o`; 1 if the result needed two reads

## Operation
- States: IDLE, RD0, RD1, OUT.
- IDLE: on `ce_i`, latch off=`addr_i[1:0]`, size, sig; set `mem_addr_o`={`addr_i[31:2]`,2'b00}; go to RD0. `ce_i` in any other state is ignored (not queued).
- RD0: `mem_req_o`=1. On `mem_ack_i`, capture lo=`mem_d_i`. If the access spans a word, go to RD1 with `mem_addr_o`+=4 (wraps 0xFFFFFFFC→0x00000000); otherwise go to OUT.
- Span rule: byte never spans; half spans iff off=3; word spans iff off≠0.
- RD1: `mem_req_o`=1. On `mem_ack_i`, capture hi=`mem_d_i`; go to OUT.
- OUT: `ce_o`=1, `d_o` updated, `split_o` valid. Next state is IDLE unconditionally.
- Extraction: form 64-bit {hi,lo} with hi=0 when not split, shift right by 8·off, and take the low 8/16/32 bits. Fill the upper bits with the MSB of the taken field if `sig_i`=1, else with 0.
- `mem_ack_i` outside RD0/RD1 is ignored. `mem_req_o` stays high across wait cycles until ack.
- `d_o` holds its last value between results.

## Timing
- All outputs are registered. Reset values: state IDLE, `busy_o`=0, `mem_req_o`=0, `mem_addr_o`=0, `ce_o`=0, `d_o`=0, `split_o`=0.
- Accept at edge T (`ce_i`=1, IDLE). `mem_req_o` rises in cycle T+1.
- Zero-wait ack: non-split result has `ce_o` in cycle T+2; split result in cycle T+3. Each bus wait cycle adds one.
- `busy_o` is high from T+1 through the OUT cycle inclusive. A new `ce_i` is accepted in the first cycle after OUT.
- Reset asserted mid-operation forces IDLE and reset values immediately. No `ce_o` is produced for the aborted load; a late ack is ignored.

## Structure
- Shared package `rv_pkg`: size encodings (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10) and the state encoding type.
- One combinational sub-module, `rv_load_extract`: inputs {hi,lo}, off, size, sig; output the 32-bit result. This keeps the lane mux separately testable.
- The FSM, address register and capture registers live in the top module.

## Test plan
- Aligned word: addr 0x100, size 10, mem returns 0xDEADBEEF with zero-wait → one request at 0x100; `ce_o` at T+2 with `d_o`=0xDEADBEEF, `split_o`=0.
- Signed byte: addr 0x103, size 00, sig 1, data 0x80112233 → `d_o`=0xFFFFFF80. Same request with sig 0 → 0x00000080.
- Split half: addr 0x203, size 01, sig 1; reads 0x200→0xAA000000 then 0x204→0x000000F1 → `d_o`=0xFFFFF1AA, `split_o`=1, `ce_o` at T+3.
- Split word with wrap: addr 0xFFFFFFFE; reads 0xFFFFFFFC→0x5566xxxx then 0x00000000→0xxxxx7788 → `d_o`=0x77885566, second `mem_addr_o`=0x00000000.
- Wait states plus ignored inputs: ack delayed 3 cycles, with `ce_i` pulsed while busy → `mem_req_o` held high, exactly one `ce_o`, the extra request is dropped, and `busy_o` falls after OUT.
- Reset mid-RD1: `rst_ni` low while waiting for the second ack → all outputs return to reset values at once; an ack arriving after reset release produces no `ce_o`.
